point_delta_gen: RTL and testbench

//   Upstream feeder for the accumulating-distance stage. Accepts a stream of (x,y) path points,

---
 rtl/point_delta_gen.sv | 115 +++++++++++
 tb/tb_point_delta_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/point_delta_gen.sv
// Point-to-point absolute delta generator: turns a stream of (x,y) path points into clipped
// per-axis deltas (a,b) behind a single-entry output register, with a sticky clip counter.
module point_delta_gen #(
  parameter int COORD_W  = 8,
  parameter int DELTA_W  = 4,
  parameter int SATCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [COORD_W-1:0]  in_x,
  input  logic [COORD_W-1:0]  in_y,
  input  logic                in_first,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DELTA_W-1:0]  a,
  output logic [DELTA_W-1:0]  b,
  output logic                out_sat,
  output logic [SATCNT_W-1:0] sat_count,
  input  logic                sat_clr
);

  localparam logic [COORD_W-1:0]  CLIP_C   = COORD_W'((1 << DELTA_W) - 1);
  localparam logic [DELTA_W-1:0]  CLIP_D   = {DELTA_W{1'b1}};
  localparam logic [SATCNT_W-1:0] SAT_MAX  = {SATCNT_W{1'b1}};

  typedef enum logic {EMPTY, HOLD} state_t;

  state_t              state_q, state_d;
  logic [COORD_W-1:0]  x_prev_q, x_prev_d;
  logic [COORD_W-1:0]  y_prev_q, y_prev_d;
  logic                out_valid_q, out_valid_d;
  logic [DELTA_W-1:0]  a_q, a_d;
  logic [DELTA_W-1:0]  b_q, b_d;
  logic                out_sat_q, out_sat_d;
  logic [SATCNT_W-1:0] sat_count_q, sat_count_d;

  logic                accept;
  logic                produce;
  logic [COORD_W-1:0]  dx, dy;
  logic                clip_x, clip_y;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign produce  = accept && (state_q == HOLD) && !in_first;

  // Subtract the smaller from the larger so the magnitude never wraps.
  assign dx     = (in_x >= x_prev_q) ? (in_x - x_prev_q) : (x_prev_q - in_x);
  assign dy     = (in_y >= y_prev_q) ? (in_y - y_prev_q) : (y_prev_q - in_y);
  assign clip_x = (dx > CLIP_C);
  assign clip_y = (dy > CLIP_C);

  always_comb begin
    state_d     = state_q;
    x_prev_d    = x_prev_q;
    y_prev_d    = y_prev_q;
    out_valid_d = out_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    out_sat_d   = out_sat_q;
    sat_count_d = sat_count_q;

    if (accept) begin
      x_prev_d = in_x;
      y_prev_d = in_y;
      state_d  = HOLD;
    end

    if (produce) begin
      a_d         = clip_x ? CLIP_D : dx[DELTA_W-1:0];
      b_d         = clip_y ? CLIP_D : dy[DELTA_W-1:0];
      out_sat_d   = clip_x || clip_y;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // Clear has priority over a coincident clipped pair.
    if (sat_clr) begin
      sat_count_d = '0;
    end else if (produce && (clip_x || clip_y) && (sat_count_q != SAT_MAX)) begin
      sat_count_d = sat_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= EMPTY;
      x_prev_q    <= '0;
      y_prev_q    <= '0;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      out_sat_q   <= 1'b0;
      sat_count_q <= '0;
    end else begin
      state_q     <= state_d;
      x_prev_q    <= x_prev_d;
      y_prev_q    <= y_prev_d;
      out_valid_q <= out_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_sat_q   <= out_sat_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign a         = a_q;
  assign b         = b_q;
  assign out_sat   = out_sat_q;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_point_delta_gen.sv
// Bench for point_delta_gen: directed table, hand-written handshake/reset/saturation sequences,
// then random traffic checked against a queue-based reference model.
module tb_point_delta_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready, in_ready2;
  logic [7:0] in_x, in_y;
  logic       in_first;
  logic       out_valid, out_valid2;
  logic       out_ready;
  logic [3:0] a, b, a2, b2;
  logic       out_sat, out_sat2;
  logic [7:0] sat_count;
  logic [1:0] sat_count2;
  logic       sat_clr;

  always #5 clk = ~clk;

  point_delta_gen #(.COORD_W(8), .DELTA_W(4), .SATCNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .in_first(in_first), .out_valid(out_valid), .out_ready(out_ready), .a(a), .b(b),
    .out_sat(out_sat), .sat_count(sat_count), .sat_clr(sat_clr));

  point_delta_gen #(.COORD_W(8), .DELTA_W(4), .SATCNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_x(in_x), .in_y(in_y),
    .in_first(in_first), .out_valid(out_valid2), .out_ready(out_ready), .a(a2), .b(b2),
    .out_sat(out_sat2), .sat_count(sat_count2), .sat_clr(sat_clr));

  int checks = 0;
  int errors = 0;

  // Reference model: expected pending pairs plus the last path point.
  typedef struct { int a; int b; bit sat; } pair_t;
  pair_t m_q[$];
  bit    m_have;
  int    m_xp, m_yp;
  int    m_cnt8, m_cnt2;

  typedef struct {
    logic [7:0] x; logic [7:0] y; logic first;
    logic emit; logic [3:0] ea; logic [3:0] eb; logic esat;
  } vec_t;
  vec_t tbl[9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit vld, input int x, input int y, input bit first,
                       input bit ordy, input bit clr, input bit rstn);
    in_valid  = vld;
    in_x      = 8'(x);
    in_y      = 8'(y);
    in_first  = first;
    out_ready = ordy;
    sat_clr   = clr;
    rst       = rstn;
  endtask

  function automatic int absdiff(input int p, input int q);
    return (p > q) ? p - q : q - p;
  endfunction

  // One clock: pre-edge ready check, model update at the edge, post-edge output checks.
  task automatic cycle();
    bit acc;
    int dx, dy;
    pair_t p;
    @(negedge clk);
    acc = 1'b0;
    if (rst) begin
      check("in_ready", int'(in_ready), int'(m_q.size() == 0 || out_ready));
      check("in_ready2", int'(in_ready2), int'(m_q.size() == 0 || out_ready));
      acc = in_valid && (m_q.size() == 0 || out_ready);
    end
    @(posedge clk);
    if (!rst) begin
      m_q.delete();
      m_have = 1'b0;
      m_xp = 0; m_yp = 0;
      m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
      if (acc) begin
        if (m_have && !in_first) begin
          dx = absdiff(int'(in_x), m_xp);
          dy = absdiff(int'(in_y), m_yp);
          p.a = (dx > 15) ? 15 : dx;
          p.b = (dy > 15) ? 15 : dy;
          p.sat = (dx > 15) || (dy > 15);
          m_q.push_back(p);
          if (p.sat) begin
            m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
            m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
          end
        end
        m_xp = int'(in_x);
        m_yp = int'(in_y);
        m_have = 1'b1;
      end
      if (sat_clr) begin
        m_cnt8 = 0;
        m_cnt2 = 0;
      end
    end
    #1;
    check("out_valid", int'(out_valid), int'(m_q.size() > 0));
    check("out_valid2", int'(out_valid2), int'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      check("a", int'(a), m_q[0].a);
      check("b", int'(b), m_q[0].b);
      check("out_sat", int'(out_sat), int'(m_q[0].sat));
    end
    check("sat_count", int'(sat_count), m_cnt8);
    check("sat_count2", int'(sat_count2), m_cnt2);
  endtask

  initial begin
    int rx, ry;

    tbl[0] = '{8'd3,   8'd5,   1'b1, 1'b0, 4'd0,  4'd0,  1'b0};
    tbl[1] = '{8'd7,   8'd2,   1'b0, 1'b1, 4'd4,  4'd3,  1'b0};
    tbl[2] = '{8'd7,   8'd2,   1'b0, 1'b1, 4'd0,  4'd0,  1'b0};
    tbl[3] = '{8'd1,   8'd1,   1'b1, 1'b0, 4'd0,  4'd0,  1'b0};
    tbl[4] = '{8'd100, 8'd100, 1'b1, 1'b0, 4'd0,  4'd0,  1'b0};
    tbl[5] = '{8'd102, 8'd99,  1'b0, 1'b1, 4'd2,  4'd1,  1'b0};
    tbl[6] = '{8'd0,   8'd0,   1'b1, 1'b0, 4'd0,  4'd0,  1'b0};
    tbl[7] = '{8'd200, 8'd10,  1'b0, 1'b1, 4'd15, 4'd10, 1'b1};
    tbl[8] = '{8'd190, 8'd12,  1'b0, 1'b1, 4'd10, 4'd2,  1'b0};

    // Reset state
    drive(0, 0, 0, 0, 1, 0, 0);
    cycle();
    cycle();
    check("rst_a", int'(a), 0);
    check("rst_b", int'(b), 0);
    check("rst_out_sat", int'(out_sat), 0);
    check("rst_in_ready", int'(in_ready), 1);
    drive(0, 0, 0, 0, 1, 0, 1);
    cycle();

    // T1/T4/T2 as a table, consumer always ready
    for (int i = 0; i < 9; i++) begin
      drive(1, tbl[i].x, tbl[i].y, tbl[i].first, 1, 0, 1);
      cycle();
      check($sformatf("tbl%0d_valid", i), int'(out_valid), int'(tbl[i].emit));
      if (tbl[i].emit) begin
        check($sformatf("tbl%0d_a", i), int'(a), int'(tbl[i].ea));
        check($sformatf("tbl%0d_b", i), int'(b), int'(tbl[i].eb));
        check($sformatf("tbl%0d_sat", i), int'(out_sat), int'(tbl[i].esat));
      end
    end
    check("t2_sat_count", int'(sat_count), 1);

    // T3: backpressure holds the pair and the waiting point
    drive(1, 3, 5, 1, 1, 0, 1); cycle();
    drive(1, 7, 2, 0, 1, 0, 1); cycle();
    drive(1, 8, 2, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t3_in_ready", int'(in_ready), 0);
      check("t3_a_hold", int'(a), 4);
      check("t3_b_hold", int'(b), 3);
    end
    drive(1, 8, 2, 0, 1, 0, 1); cycle();
    check("t3_valid_stays", int'(out_valid), 1);
    check("t3_a_next", int'(a), 1);
    check("t3_b_next", int'(b), 0);
    drive(0, 0, 0, 0, 1, 0, 1); cycle();
    check("t3_drain", int'(out_valid), 0);

    // T5: 2-bit counter saturates, clear beats coincident clipped pair
    drive(1, 0, 0, 1, 1, 0, 1); cycle();
    for (int i = 0; i < 4; i++) begin
      drive(1, (i % 2 == 0) ? 200 : 0, 0, 0, 1, 0, 1);
      cycle();
    end
    check("t5_sat_stick", int'(sat_count2), 3);
    drive(1, 200, 0, 0, 1, 1, 1); cycle();
    check("t5_clr2", int'(sat_count2), 0);
    check("t5_clr8", int'(sat_count), 0);
    check("t5_clipped_pair", int'(out_sat), 1);

    // T6: reset during a stalled handshake
    drive(1, 10, 10, 0, 0, 0, 1); cycle();
    drive(1, 11, 10, 0, 0, 0, 0); cycle();
    check("t6_valid", int'(out_valid), 0);
    check("t6_a", int'(a), 0);
    check("t6_b", int'(b), 0);
    drive(1, 50, 50, 0, 1, 0, 1); cycle();
    check("t6_no_emit", int'(out_valid), 0);
    drive(1, 52, 50, 0, 1, 0, 1); cycle();
    check("t6_emit_a", int'(a), 2);
    check("t6_emit_b", int'(b), 0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        rx = $urandom_range(0, 255);
        ry = $urandom_range(0, 255);
      end else begin
        rx = m_xp + int'($urandom_range(0, 40)) - 20;
        ry = m_yp + int'($urandom_range(0, 40)) - 20;
        rx = (rx < 0) ? 0 : (rx > 255) ? 255 : rx;
        ry = (ry < 0) ? 0 : (ry > 255) ? 255 : ry;
      end
      drive($urandom_range(0, 3) != 0, rx, ry, $urandom_range(0, 7) == 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 60) == 0,
            $urandom_range(0, 199) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
